// File: rtl/sort_drain.sv
// sort_drain: output stage behind the bubble sorter.
//
// Captures one finished N-element signed block in parallel, then streams it
// out one element per valid/ready handshake. While streaming it checks that
// adjacent elements never descend (signed), and it reports the block min/max
// (elements 0 and N-1) and a running count of fully drained blocks.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready block handshake; in_ready is high only in IDLE
//   in_data           flattened block, element i at [i*WIDTH +: WIDTH]
//   out_valid/ready   element handshake
//   out_data          current element (signed)
//   out_index         index of the current element, 0..N-1
//   out_last          high with out_valid on element N-1
//   order_error       sticky descending-pair flag, cleared on capture
//   min_value         element 0 of the last captured block
//   max_value         element N-1 of the last captured block
//   block_count       blocks fully drained since reset (wraps)
//   o_dbg_state       current FSM state (0 = IDLE, 1 = DRAIN)
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid never depends on ready, and while valid is high and
// ready is low the presented data/index/last stay unchanged.
module sort_drain #(
    parameter int N     = 8,
    parameter int WIDTH = 32,
    parameter int IDXW  = 3,
    parameter int CNTW  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDXW-1:0]      out_index,
    output logic                 out_last,
    output logic                 order_error,
    output logic [WIDTH-1:0]     min_value,
    output logic [WIDTH-1:0]     max_value,
    output logic [CNTW-1:0]      block_count,
    output logic                 o_dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic signed [WIDTH-1:0]  r_buf [N];
    logic [IDXW-1:0]          r_index;
    logic                     r_order_error;
    logic [WIDTH-1:0]         r_min;
    logic [WIDTH-1:0]         r_max;
    logic [CNTW-1:0]          r_count;

    logic                     w_capture;
    logic                     w_accept;
    logic                     w_is_last;
    logic [IDXW-1:0]          w_prev_idx;
    logic signed [WIDTH-1:0]  w_cur;
    logic signed [WIDTH-1:0]  w_prev;
    logic                     w_descend;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && w_is_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_capture  = in_valid && in_ready;
    assign w_accept   = out_valid && out_ready;
    assign w_is_last  = (r_index == LAST_IDX);
    // At index 0 this wraps, but the result is masked out of w_descend.
    assign w_prev_idx = r_index - 1'b1;
    assign w_cur      = r_buf[r_index];
    assign w_prev     = r_buf[w_prev_idx];
    // Signed compare; equal neighbours are legal.
    assign w_descend  = (r_index != '0) && (w_cur < w_prev);

    // Block buffer: loaded only on capture, so in_data is ignored in DRAIN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Stream index, order check and block statistics
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_index       <= '0;
            r_order_error <= 1'b0;
            r_min         <= '0;
            r_max         <= '0;
            r_count       <= '0;
        end else if (w_capture) begin
            r_index       <= '0;
            r_order_error <= 1'b0;
            r_min         <= in_data[0 +: WIDTH];
            r_max         <= in_data[(N-1)*WIDTH +: WIDTH];
        end else if (w_accept) begin
            if (w_descend) begin
                r_order_error <= 1'b1;
            end
            if (w_is_last) begin
                r_index <= '0;
                r_count <= r_count + 1'b1;
            end else begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign out_data    = w_cur;
    assign out_index   = r_index;
    assign out_last    = out_valid && w_is_last;
    assign order_error = r_order_error;
    assign min_value   = r_min;
    assign max_value   = r_max;
    assign block_count = r_count;
    assign o_dbg_state = r_state;

endmodule
